// File: rtl/stopwatch_pkg.sv
// Shared constants for the MM:SS stopwatch controller: FSM encoding,
// per-digit blank bit positions and the default field moduli.
package stopwatch_pkg;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Bit positions inside blank {min_t, min_o, sec_t, sec_o}
    localparam int BLK_SEC_O = 0;
    localparam int BLK_SEC_T = 1;
    localparam int BLK_MIN_O = 2;
    localparam int BLK_MIN_T = 3;

    localparam int DEF_SEC_MOD = 60;
    localparam int DEF_MIN_MOD = 60;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle of strobes, user controls and display outputs of the stopwatch
// controller. The master side drives strobes/controls, the slave side
// (the controller) drives the BCD value, blanking and run status.
interface stopwatch_ctrl_if;

    logic       one_hz;
    logic       two_hz;
    logic       blink_lvl;
    logic       pause_btn;
    logic       adj;
    logic       sel;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [3:0] blank;
    logic       running;

    modport master (
        output one_hz, two_hz, blink_lvl, pause_btn, adj, sel,
        input  min_bcd, sec_bcd, blank, running
    );

    modport slave (
        input  one_hz, two_hz, blink_lvl, pause_btn, adj, sel,
        output min_bcd, sec_bcd, blank, running
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD (MOD a multiple of 10, 10..100).
// wrap flags the increment that rolls MOD-1 back to 00 so the caller can
// use it as a carry.
module bcd_mod_counter #(
    parameter int MOD = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] bcd,
    output logic       wrap
);

    localparam logic [3:0] TENS_LAST = 4'(MOD / 10 - 1);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       at_last;

    assign at_last = (tens_q == TENS_LAST) && (ones_q == 4'd9);
    assign wrap    = inc & at_last;
    assign bcd     = {tens_q, ones_q};

    // Next digit values: ones roll 9->0 and ripple into tens, tens roll at the modulus.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (inc) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == TENS_LAST) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: run/pause FSM, count and adjust steering of
// the seconds/minutes counters, and registered blink blanking.
// The one_hz tick is judged on the pre-toggle FSM state, so a press and a
// tick in the same cycle count first and then pause.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SEC_MOD = DEF_SEC_MOD,
    parameter int MIN_MOD = DEF_MIN_MOD
) (
    input  logic                   clk,
    input  logic                   rst,
    stopwatch_ctrl_if.slave        bus
);

    state_t     state_q, state_d;
    logic [3:0] blank_q, blank_d;
    logic       sec_inc, min_inc, sec_wrap, min_wrap_unused;

    // In adjust mode only two_hz acts (on the selected field, no carry);
    // otherwise one_hz counts in RUN and seconds carry into minutes.
    assign sec_inc = bus.adj ? (bus.two_hz & bus.sel)
                             : (bus.one_hz & (state_q == ST_RUN));
    assign min_inc = bus.adj ? (bus.two_hz & ~bus.sel) : sec_wrap;

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk  (clk),
        .rst  (rst),
        .inc  (sec_inc),
        .bcd  (bus.sec_bcd),
        .wrap (sec_wrap)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk  (clk),
        .rst  (rst),
        .inc  (min_inc),
        .bcd  (bus.min_bcd),
        .wrap (min_wrap_unused)
    );

    // Next state and next blanking: a press toggles run/pause in any mode;
    // the selected field goes dark during the blink off phase in adjust.
    always_comb begin
        state_d = state_q;
        blank_d = 4'b0000;
        if (bus.pause_btn) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
        if (bus.adj && bus.blink_lvl) begin
            if (bus.sel) begin
                blank_d[BLK_SEC_T] = 1'b1;
                blank_d[BLK_SEC_O] = 1'b1;
            end else begin
                blank_d[BLK_MIN_T] = 1'b1;
                blank_d[BLK_MIN_O] = 1'b1;
            end
        end
    end

    // State and blank registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PAUSE;
            blank_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
        end
    end

    assign bus.running = (state_q == ST_RUN);
    assign bus.blank   = blank_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl. Each driven cycle updates a
// decimal reference model and queues the expected {running, min, sec, blank}
// which is compared one clock later, after the DUT registers settle.
module tb_stopwatch_ctrl;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

    logic clk;
    logic rst;
    stopwatch_ctrl_if ifc ();

    stopwatch_ctrl #(.SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model / scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_min   = 0;
    int         m_sec   = 0;
    bit         m_run   = 1'b0;
    logic [3:0] m_blank = 4'b0000;
    logic [20:0] exp_q[$];

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the registered result, compare it.
    task automatic drive_cycle(input string tag, input logic r, input logic oh, input logic th,
                               input logic pb, input logic a, input logic s, input logic bl);
        logic [20:0] got, exp;
        logic        legal;
        rst           = r;
        ifc.one_hz    = oh;
        ifc.two_hz    = th;
        ifc.pause_btn = pb;
        ifc.adj       = a;
        ifc.sel       = s;
        ifc.blink_lvl = bl;
        if (r) begin
            m_min = 0; m_sec = 0; m_run = 1'b0; m_blank = 4'b0000;
        end else begin
            if (a) begin
                if (th) begin
                    if (s) m_sec = (m_sec + 1) % SEC_MOD;
                    else   m_min = (m_min + 1) % MIN_MOD;
                end
            end else if (m_run && oh) begin
                if (m_sec == SEC_MOD - 1) begin
                    m_sec = 0;
                    m_min = (m_min + 1) % MIN_MOD;
                end else begin
                    m_sec = m_sec + 1;
                end
            end
            if (pb) m_run = !m_run;
            m_blank = (a && bl) ? (s ? 4'b0011 : 4'b1100) : 4'b0000;
        end
        exp_q.push_back({m_run, to_bcd(m_min), to_bcd(m_sec), m_blank});
        @(posedge clk);
        #1;
        got = {ifc.running, ifc.min_bcd, ifc.sec_bcd, ifc.blank};
        exp = exp_q.pop_front();
        check_eq(tag, 32'(got), 32'(exp));
        legal = (ifc.min_bcd[7:4] < 4'(MIN_MOD / 10)) && (ifc.min_bcd[3:0] <= 4'd9) &&
                (ifc.sec_bcd[7:4] < 4'(SEC_MOD / 10)) && (ifc.sec_bcd[3:0] <= 4'd9);
        check_eq({tag, "_bcd_legal"}, 32'(legal), 32'd1);
    endtask

    task automatic idle(input string tag, input int n, input logic a, input logic s);
        for (int i = 0; i < n; i++) drive_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, a, s, 1'b0);
    endtask

    // One one_hz tick followed by a random gap of idle cycles.
    task automatic tick_1hz(input string tag);
        drive_cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(tag, $urandom_range(0, 2), 1'b0, 1'b0);
    endtask

    // Adjust-mode fast set: n two_hz pulses on the selected field, with a
    // stray one_hz in the same cycle now and then (must be ignored).
    task automatic adj_pulses(input string tag, input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            drive_cycle(tag, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, s, 1'b0);
            if ($urandom_range(0, 3) == 0)
                drive_cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, s, 1'b0);
        end
    endtask

    task automatic press(input string tag);
        drive_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        ifc.one_hz = 1'b0; ifc.two_hz = 1'b0; ifc.pause_btn = 1'b0;
        ifc.adj = 1'b0; ifc.sel = 1'b0; ifc.blink_lvl = 1'b0;

        // Reset state
        drive_cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_running", 32'(ifc.running), 32'd0);
        check_eq("reset_blank", 32'(ifc.blank), 32'd0);

        // Paused ticks are ignored
        for (int i = 0; i < 3; i++) tick_1hz("paused_tick");
        check_eq("paused_min", 32'(ifc.min_bcd), 32'h00);
        check_eq("paused_sec", 32'(ifc.sec_bcd), 32'h00);

        // Start and count 61 seconds
        press("start");
        for (int i = 0; i < 61; i++) tick_1hz("count61");
        check_eq("count61_running", 32'(ifc.running), 32'd1);
        check_eq("count61_value", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h0101);

        // Preload 59:58 through adjust (from 01:01), then count across 59:59 -> 00:00
        adj_pulses("adj_min", 58, 1'b0);
        adj_pulses("adj_sec", 57, 1'b1);
        check_eq("preload_value", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h5958);
        idle("leave_adj", 1, 1'b0, 1'b0);
        tick_1hz("wrap_tick");
        check_eq("wrap_5959", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h5959);
        drive_cycle("wrap_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("wrap_0000", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h0000);

        // Seconds adjust to 58, then 3 pulses with blink, no carry into minutes
        adj_pulses("adj_sec58", 58, 1'b1);
        drive_cycle("blink_on", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("adj_sec59", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h0059);
        check_eq("blank_on_sec", 32'(ifc.blank), 32'b0011);
        drive_cycle("blink_off", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("adj_sec00", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h0000);
        check_eq("blank_off_sec", 32'(ifc.blank), 32'b0000);
        drive_cycle("blink_on2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("adj_sec01", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h0001);
        drive_cycle("blink_min", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("blank_on_min", 32'(ifc.blank), 32'b1100);
        drive_cycle("adj_exit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("blank_noadj", 32'(ifc.blank), 32'b0000);

        // Press and tick together at 00:10
        drive_cycle("rst2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        press("start2");
        for (int i = 0; i < 10; i++) tick_1hz("to_0010");
        drive_cycle("press_tick", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("press_tick_value", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h0011);
        check_eq("press_tick_running", 32'(ifc.running), 32'd0);
        for (int i = 0; i < 3; i++) tick_1hz("after_pause");
        check_eq("after_pause_value", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h0011);

        // Reach 12:34 running, then reset together with a tick
        adj_pulses("set12", 12, 1'b0);
        adj_pulses("set34", 23, 1'b1);
        drive_cycle("run_in_adj", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle("leave_adj2", 1, 1'b0, 1'b0);
        check_eq("value_1234", 32'({ifc.min_bcd, ifc.sec_bcd}), 32'h1234);
        check_eq("running_1234", 32'(ifc.running), 32'd1);
        drive_cycle("rst_tick", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst_tick_all", 32'({ifc.running, ifc.min_bcd, ifc.sec_bcd, ifc.blank}), 32'd0);

        // Random mixed traffic against the model
        press("start3");
        for (int i = 0; i < 400; i++) begin
            drive_cycle("random", 1'b0,
                        1'($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 15) == 0),
                        1'($urandom_range(0, 4) == 0),
                        1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
